// File: rtl/bm_wr_pkg.sv
// BM write controller shared definitions.
// BM_DEPTH / BM_DATA_WIDTH normally arrive from incl.vh. The fallbacks below
// let this slice build on its own.
`ifndef BM_DEPTH
`define BM_DEPTH 16
`endif
`ifndef BM_DATA_WIDTH
`define BM_DATA_WIDTH 8
`endif

package bm_wr_pkg;

    localparam int BM_DEPTH_DEF = `BM_DEPTH;
    localparam int BM_DW_DEF    = `BM_DATA_WIDTH;

    // True when a burst starting at addr with len words would run past the last entry.
    function automatic logic range_bad(input logic [31:0] addr,
                                       input logic [31:0] len,
                                       input logic [31:0] depth);
        return (addr + len) > depth;
    endfunction

endpackage

// File: rtl/bm_wr_addr_gen.sv
// Burst address/length tracker for the BM write controller.
// It loads on command accept and steps on each data beat.
// The last flag marks the final beat of the burst.
module bm_wr_addr_gen #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [AW:0]   load_len,
    input  logic          step,
    output logic [AW-1:0] cur,
    output logic          last
);

    logic [AW:0] rem;

    // cur wraps naturally modulo DEPTH. rem counts the words still owed.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur <= '0;
            rem <= '0;
        end else if (load) begin
            cur <= load_addr;
            rem <= load_len;
        end else if (step) begin
            cur <= cur + AW'(1);
            rem <= rem - (AW+1)'(1);
        end
    end

    assign last = (rem == (AW+1)'(1));

endmodule

// File: rtl/bm_wr_ctrl.sv
// BM write controller.
// It takes a burst command and then streams data into the BM write port.
// Write addresses are registered and auto-increment.
// Optional macro BM_WR_RANGE_CHK_EN: when defined, the controller rejects any
// burst that would run past the last BM entry and raises a sticky err.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  ST_IDLE | waiting for a command (cmd_rdy=1)
//  ST_WR   | accepting data beats (din_rdy=1)
//  ST_DONE | one-cycle done pulse; the final write is on the port
module bm_wr_ctrl
    import bm_wr_pkg::*;
#(
    parameter  int DEPTH = BM_DEPTH_DEF,
    parameter  int DW    = BM_DW_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_vld,
    output logic          cmd_rdy,
    input  logic [AW-1:0] cmd_addr,
    input  logic [AW:0]   cmd_len,
    input  logic          din_vld,
    output logic          din_rdy,
    input  logic [DW-1:0] din,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cur;
    logic          last;
    logic          cmd_acc;
    logic          beat;
    logic          bad;

    assign cmd_acc = cmd_vld && cmd_rdy;
    assign beat    = din_vld && din_rdy;

`ifdef BM_WR_RANGE_CHK_EN
    assign bad = range_bad(32'(cmd_addr), 32'(cmd_len), 32'(DEPTH));
`else
    assign bad = 1'b0;
`endif

    bm_wr_addr_gen #(.AW(AW)) u_addr_gen (
        .clk       (clk),
        .rstn      (rstn),
        .load      (cmd_acc),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .step      (beat),
        .cur       (cur),
        .last      (last)
    );

    // State register. Reset drops any in-flight burst without a done pulse.
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and state-decoded handshake/status outputs.
    always_comb begin
        state_nxt = state;
        cmd_rdy   = 1'b0;
        din_rdy   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_vld) begin
                    if (bad || (cmd_len == '0)) state_nxt = ST_DONE;
                    else                        state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                din_rdy = 1'b1;
                if (din_vld && last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Write port registers. Address and data hold their values between beats.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= beat;
            if (beat) begin
                wr_addr <= cur;
                wr_data <= din;
            end
        end
    end

`ifdef BM_WR_RANGE_CHK_EN
    // Sticky range error. Only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn)               err <= 1'b0;
        else if (cmd_acc && bad) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bm_wr_ctrl.sv
// Scoreboard bench for bm_wr_ctrl (DEPTH=16, DW=8).
module tb_bm_wr_ctrl;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_vld = 1'b0;
    logic          cmd_rdy;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          din_vld = 1'b0;
    logic          din_rdy;
    logic [DW-1:0] din = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int done_exp = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    always #5 clk = ~clk;

    bm_wr_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .din      (din),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: each write on the BM port must match the oldest expected write.
    always @(negedge clk) begin
        if (done) done_seen++;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                note_fail("unexpected_write");
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(wr_data), 32'(mon_e.data));
                chk("wr_done_align", 32'(done), 32'(mon_e.last));
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_cmd(input int addr, input int len);
        bit ok;
        int n;
        n = 0;
        cmd_addr = AW'(addr);
        cmd_len  = (AW+1)'(len);
        cmd_vld  = 1'b1;
        do begin
            ok = cmd_rdy;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 50);
        cmd_vld = 1'b0;
        if (!ok) note_fail("cmd_timeout");
    endtask

    task automatic send_beat(input int exp_addr, input logic [DW-1:0] data, input bit last);
        bit ok;
        int n;
        n = 0;
        din     = data;
        din_vld = 1'b1;
        do begin
            ok = din_rdy;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 50);
        din_vld = 1'b0;
        if (!ok) note_fail("beat_timeout");
        else exp_q.push_back('{addr: AW'(exp_addr), data: data, last: last});
    endtask

    task automatic burst(input int addr, input int len, input logic [DW-1:0] seed, input int gap);
        send_cmd(addr, len);
        for (int i = 0; i < len; i++) begin
            send_beat((addr + i) % DEPTH, seed + DW'(i), i == len - 1);
            if (i != len - 1)
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
        end
        done_exp++;
        chk("done_pulse", 32'(done), 1);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_cmd_rdy", 32'(cmd_rdy), 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", 32'(cmd_rdy), 1);
        chk("rst_din_rdy", 32'(din_rdy), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Basic burst: addr 5, A0/A1/A2 back to back
        burst(5, 3, 8'hA0, 0);

        // Stalls: din_vld low every other cycle
        burst(9, 4, 8'h30, 1);

        // Upper boundary: 12+4 == DEPTH is in range
        burst(12, 4, 8'h50, 0);
        chk("boundary_err", 32'(err), 0);

        // Zero length, with a stray beat offered that must not be taken
        din = 8'h77;
        din_vld = 1'b1;
        chk("idle_din_rdy", 32'(din_rdy), 0);
        send_cmd(2, 0);
        done_exp++;
        chk("zero_done", 32'(done), 1);
        chk("zero_wr_en", 32'(wr_en), 0);
        chk("zero_din_rdy", 32'(din_rdy), 0);
        @(posedge clk); #1;
        din_vld = 1'b0;
        chk("zero_done_clear", 32'(done), 0);
        chk("zero_cmd_rdy", 32'(cmd_rdy), 1);

`ifdef BM_WR_RANGE_CHK_EN
        // Range check: 14+4 > DEPTH
        send_cmd(14, 4);
        done_exp++;
        din = 8'h55;
        din_vld = 1'b1;
        chk("range_done", 32'(done), 1);
        chk("range_err", 32'(err), 1);
        chk("range_din_rdy", 32'(din_rdy), 0);
        @(posedge clk); #1;
        chk("range_done_clear", 32'(done), 0);
        chk("range_din_rdy2", 32'(din_rdy), 0);
        chk("range_err_sticky", 32'(err), 1);
        din_vld = 1'b0;
`else
        // Wrap: 14,15,0,1
        burst(14, 4, 8'hC0, 0);
        chk("wrap_err", 32'(err), 0);
`endif

        // Reset mid-burst after 2 of 4 beats
        send_cmd(3, 4);
        send_beat(3, 8'h11, 1'b0);
        send_beat(4, 8'h12, 1'b0);
        din = 8'h13;
        din_vld = 1'b1;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        din_vld = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_cmd_rdy", 32'(cmd_rdy), 1);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_wr_en", 32'(wr_en), 0);
        chk("rst_mid_err", 32'(err), 0);

        // Full-depth burst after recovery
        burst(0, DEPTH, 8'h80, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        chk("done_count", 32'(done_seen), 32'(done_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
